// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: shared types and sizing helpers for the fixed-point divider.
`default_nettype none

package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic RND_TRUNC  = 1'b0;
  localparam logic RND_HALFUP = 1'b1;

  // One quotient bit per numerator/fraction bit plus one guard bit.
  function automatic int calc_iter(input int dw, input int frac);
    return dw + frac + 1;
  endfunction

  function automatic int calc_cnt_w(input int iter);
    return $clog2(iter + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fxp_div_if.sv
// fxp_div_if: Start/Ack request bus between the host and the divider.
`default_nettype none

interface fxp_div_if #(
  parameter int DW = 16,
  parameter int VW = 16,
  parameter int QW = 16
);
  logic          start;
  logic [DW-1:0] num;
  logic [VW-1:0] den;
  logic          rnd;
  logic [QW-1:0] quot;
  logic          div_zero;
  logic          ovf;
  logic          busy;
  logic          ack;

  modport master (
    output start, num, den, rnd,
    input  quot, div_zero, ovf, busy, ack
  );

  modport slave (
    input  start, num, den, rnd,
    output quot, div_zero, ovf, busy, ack
  );
endinterface

`default_nettype wire

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational radix-2 restoring division iteration.
`default_nettype none

module fxp_div_step #(
  parameter int VW = 16
) (
  input  logic [VW:0]   rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] den_i,
  output logic [VW:0]   rem_next_o,
  output logic          q_bit_o
);
  logic [VW:0] trial;

  assign trial = {rem_i[VW-1:0], bit_i};

  // A set remainder MSB means the shifted value exceeds any VW-bit divisor;
  // the modulo-2^(VW+1) subtraction is still exact because the result < den.
  assign q_bit_o    = rem_i[VW] | (trial >= {1'b0, den_i});
  assign rem_next_o = q_bit_o ? (trial - {1'b0, den_i}) : trial;

endmodule

`default_nettype wire

// File: rtl/fxp_div_unit.sv
// fxp_div_unit: sequential fixed-point divider, Quot = (Num * 2^FRAC) / Den,
// truncating or half-LSB rounding, saturating to all ones.
`default_nettype none

module fxp_div_unit
  import fxp_div_pkg::*;
#(
  parameter int DW   = 16,
  parameter int VW   = 16,
  parameter int QW   = 16,
  parameter int FRAC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fxp_div_if.slave    div_bus
);
  localparam int ITER  = calc_iter(DW, FRAC);
  localparam int CNT_W = calc_cnt_w(ITER);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [VW:0]       rem_q;
  logic [ITER-1:0]   sh_q;
  logic [VW-1:0]     den_q;
  logic              rnd_q;
  logic              dz_flag_q;
  logic [QW-1:0]     quot_q;
  logic              div_zero_q;
  logic              ovf_q;
  logic              busy_q;
  logic              ack_q;

  logic [VW:0]       rem_d;
  logic              q_bit_d;

  // Dividend bits leave at the top of sh_q while quotient bits enter at the
  // bottom, so after ITER steps sh_q holds the full quotient incl. guard bit.
  fxp_div_step #(.VW(VW)) u_step (
    .rem_i      (rem_q),
    .bit_i      (sh_q[ITER-1]),
    .den_i      (den_q),
    .rem_next_o (rem_d),
    .q_bit_o    (q_bit_d)
  );

  logic [ITER-1:0]    q_rnd;
  logic [ITER+QW-1:0] q_ext;
  logic               q_ovf;

  assign q_rnd = {1'b0, sh_q[ITER-1:1]}
               + {{(ITER-1){1'b0}}, (rnd_q == RND_HALFUP) & sh_q[0]};
  assign q_ext = {{QW{1'b0}}, q_rnd};
  assign q_ovf = |q_ext[ITER+QW-1:QW];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      sh_q       <= '0;
      den_q      <= '0;
      rnd_q      <= RND_TRUNC;
      dz_flag_q  <= 1'b0;
      quot_q     <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (div_bus.start) begin
            den_q      <= div_bus.den;
            rnd_q      <= div_bus.rnd;
            ack_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            rem_q      <= '0;
            sh_q       <= {div_bus.num, {(FRAC+1){1'b0}}};
            dz_flag_q  <= (div_bus.den == '0);
            state_q    <= (div_bus.den == '0) ? ROUND : RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          sh_q  <= {sh_q[ITER-2:0], q_bit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (dz_flag_q) begin
            quot_q     <= '1;
            div_zero_q <= 1'b1;
          end else if (q_ovf) begin
            quot_q <= '1;
            ovf_q  <= 1'b1;
          end else begin
            quot_q <= q_ext[QW-1:0];
          end
          busy_q  <= 1'b0;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_bus.quot     = quot_q;
  assign div_bus.div_zero = div_zero_q;
  assign div_bus.ovf      = ovf_q;
  assign div_bus.busy     = busy_q;
  assign div_bus.ack      = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_fxp_div_unit.sv
// tb_fxp_div_unit: directed vector table, reset/handshake sequences and a
// randomised run against a behavioural divider model.
`default_nettype none

module tb_fxp_div_unit;
  localparam int DW   = 16;
  localparam int VW   = 16;
  localparam int QW   = 16;
  localparam int FRAC = 16;
  localparam int LAT  = DW + FRAC + 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fxp_div_if #(.DW(DW), .VW(VW), .QW(QW)) div_bus ();

  fxp_div_unit #(.DW(DW), .VW(VW), .QW(QW), .FRAC(FRAC)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .div_bus (div_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] num;
    logic [15:0] den;
    logic        rnd;
    logic [15:0] quot;
    logic        dz;
    logic        ovf;
    int          edges;
    int          hold;
  } vec_t;

  vec_t vecs[12];

  // Returns at the negedge where Ack is first seen; edges counts the
  // sampling edge as 1, or is -1 if Ack never rose.
  task automatic launch(input logic [15:0] n, input logic [15:0] d, input logic r,
                        input int hold, input bit noise, input bit b2b, output int edges);
    if (!b2b) @(negedge clk);
    div_bus.start = 1'b1;
    div_bus.num   = n;
    div_bus.den   = d;
    div_bus.rnd   = r;
    @(posedge clk);
    edges = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      div_bus.num = 16'($urandom);
      div_bus.den = 16'($urandom);
      div_bus.rnd = 1'($urandom);
      if (i == 0) check("busy_after_launch", 64'(div_bus.busy), 64'd1);
      if (div_bus.ack) begin
        div_bus.start = 1'b0;
        return;
      end
      div_bus.start = (i < hold - 1) || (noise && ($urandom_range(0, 3) == 0));
      @(posedge clk);
      edges++;
    end
    div_bus.start = 1'b0;
    edges = -1;
  endtask

  task automatic expect_result(input string tag, input int edges, input int exp_edges,
                               input logic [15:0] q, input logic dz, input logic ov);
    check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
    check({tag, "_quot"},    64'(div_bus.quot), 64'(q));
    check({tag, "_divzero"}, 64'(div_bus.div_zero), 64'(dz));
    check({tag, "_ovf"},     64'(div_bus.ovf), 64'(ov));
    check({tag, "_busy"},    64'(div_bus.busy), 64'd0);
  endtask

  function automatic void model(input logic [15:0] n, input logic [15:0] d, input logic r,
                                output logic [15:0] q, output logic dz, output logic ov);
    logic [63:0] full;
    logic [63:0] qq;
    dz = 1'b0;
    ov = 1'b0;
    if (d == 16'd0) begin
      q  = 16'hFFFF;
      dz = 1'b1;
    end else begin
      full = ({48'd0, n} << (FRAC + 1)) / {48'd0, d};
      qq   = (full >> 1) + (r ? {63'd0, full[0]} : 64'd0);
      if (qq >= 64'h1_0000) begin
        q  = 16'hFFFF;
        ov = 1'b1;
      end else begin
        q = qq[15:0];
      end
    end
  endfunction

  initial begin
    int          edges;
    logic [15:0] n;
    logic [15:0] d;
    logic        r;
    logic [15:0] eq;
    logic        edz;
    logic        eov;

    vecs[0]  = '{16'h0001, 16'h0004, 1'b0, 16'h4000, 1'b0, 1'b0, LAT, 2};
    vecs[1]  = '{16'h0001, 16'h0006, 1'b0, 16'h2AAA, 1'b0, 1'b0, LAT, 1};
    vecs[2]  = '{16'h0001, 16'h0006, 1'b1, 16'h2AAB, 1'b0, 1'b0, LAT, 1};
    vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0, 2,   1};
    vecs[4]  = '{16'h0001, 16'd400,  1'b0, 16'h00A3, 1'b0, 1'b0, LAT, 1};
    vecs[5]  = '{16'h0001, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b1, LAT, 1};
    vecs[6]  = '{16'h0000, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b0, LAT, 1};
    vecs[7]  = '{16'h0005, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 2,   1};
    vecs[8]  = '{16'hFFFE, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 1'b0, LAT, 1};
    vecs[9]  = '{16'hFFFE, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0, LAT, 1};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b1, LAT, 1};
    vecs[11] = '{16'h0002, 16'h0003, 1'b1, 16'hAAAB, 1'b0, 1'b0, LAT, 1};

    rst = 1'b1;
    div_bus.start = 1'b0;
    div_bus.num   = '0;
    div_bus.den   = '0;
    div_bus.rnd   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_quot",    64'(div_bus.quot), 64'd0);
    check("reset_ack",     64'(div_bus.ack), 64'd0);
    check("reset_busy",    64'(div_bus.busy), 64'd0);
    check("reset_divzero", 64'(div_bus.div_zero), 64'd0);
    check("reset_ovf",     64'(div_bus.ovf), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].num, vecs[i].den, vecs[i].rnd, vecs[i].hold, 1'b0, 1'b0, edges);
      expect_result($sformatf("vec%0d", i), edges, vecs[i].edges,
                    vecs[i].quot, vecs[i].dz, vecs[i].ovf);
    end

    // Results must hold while the unit idles in DONE.
    repeat (5) @(negedge clk);
    check("hold_quot", 64'(div_bus.quot), 64'hAAAB);
    check("hold_ack",  64'(div_bus.ack), 64'd1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    div_bus.start = 1'b1;
    div_bus.num   = 16'h0001;
    div_bus.den   = 16'h0004;
    div_bus.rnd   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    div_bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_ack",  64'(div_bus.ack), 64'd0);
    check("midrun_rst_busy", 64'(div_bus.busy), 64'd0);
    check("midrun_rst_quot", 64'(div_bus.quot), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle_busy", 64'(div_bus.busy), 64'd0);
    launch(16'h0003, 16'h0002, 1'b0, 1, 1'b0, 1'b0, edges);
    expect_result("after_rst", edges, LAT, 16'hFFFF, 1'b0, 1'b1);

    // Back-to-back launch straight from DONE.
    launch(16'h0001, 16'h0004, 1'b1, 1, 1'b0, 1'b1, edges);
    expect_result("b2b", edges, LAT, 16'h4000, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 15) == 0) d = 16'd0;
      n = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, int'(d)));
      r = 1'($urandom);
      model(n, d, r, eq, edz, eov);
      launch(n, d, r, $urandom_range(1, 3), 1'b1, 1'($urandom), edges);
      expect_result($sformatf("rand%0d", k), edges, (d == 16'd0) ? 2 : LAT, eq, edz, eov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
